pll_cfg_responder: RTL and testbench

Memory-mapped PLL reconfiguration responder on the CLK_50M management domain. It is the slave end of the mode/fractional-M/start write sequence the top-level issues on NTSC/PAL change. It latches shadow registers and, on a START write, serialises the shadow set into the PLL's configuration chain. It pulses an update strobe and holds waitrequest until the PLL relocks or a timeout expires.

---
 rtl/pll_cfg_pkg.sv | 24 ++
 rtl/pll_cfg_shifter.sv | 44 ++++
 rtl/pll_cfg_responder.sv | 168 ++++++++++++++++
 tb/tb_pll_cfg_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration responder: register map,
// frame geometry and controller states.
package pll_cfg_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_K      = 6'd7;

  localparam int FRAME_BITS = 64;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    UPDATE,
    WAIT_UNLOCK,
    WAIT_LOCK,
    DONE
  } cfg_state_t;

endpackage

// File: rtl/pll_cfg_shifter.sv
// Parallel-load shift register that serialises the configuration frame MSB
// first, one bit per cycle while go is high.
module pll_cfg_shifter
  import pll_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  go,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sdata,
  output logic                  shift,
  output logic                  last
);

  logic [FRAME_BITS-1:0] frame_p0;
  logic [CNT_W-1:0]      cnt_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift  <= 1'b0;
      sdata  <= 1'b0;
      cnt_p0 <= '0;
    end else begin
      shift <= go;
      sdata <= go ? frame_p0[FRAME_BITS-1] : 1'b0;
      if (load)
        cnt_p0 <= CNT_W'(FRAME_BITS - 1);
      else if (go && cnt_p0 != '0)
        cnt_p0 <= cnt_p0 - 1'b1;
    end
  end

  // Frame data carries no reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (load)
      frame_p0 <= frame;
    else if (go)
      frame_p0 <= {frame_p0[FRAME_BITS-2:0], 1'b0};
  end

  assign last = (cnt_p0 == '0);

endmodule

// File: rtl/pll_cfg_responder.sv
// Memory-mapped PLL reconfiguration slave: shadow registers, serial frame
// shift-out, update strobe and relock/timeout tracking.
module pll_cfg_responder
  import pll_cfg_pkg::*;
#(
  parameter logic [15:0] LOCK_TIMEOUT = 16'd50000,
  parameter logic [7:0]  RELOCK_MIN   = 8'd16
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic        mgmt_read,
  input  logic [31:0] mgmt_writedata,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic        cfg_sdata,
  output logic        cfg_shift,
  output logic        cfg_update,
  input  logic        pll_locked,
  output logic        busy
);

  cfg_state_t  state;
  logic        mode;
  logic [15:0] reg_n;
  logic [15:0] reg_m;
  logic [31:0] reg_k;
  logic        last_timeout;
  logic        start_held;
  logic [15:0] tmo_cnt;
  logic [7:0]  low_cnt;
  logic        lock_s1;
  logic        lock_s2;
  logic        shift_last;

  logic is_start_req;
  logic start_stall;
  logic start_go;
  logic wr_accept;

  assign is_start_req = mgmt_write && (mgmt_address == ADDR_START);
  assign start_stall  = is_start_req && !mode;
  assign start_go     = (state == IDLE) && is_start_req;
  assign wr_accept    = (state == IDLE) && mgmt_write && !mgmt_waitrequest;
  assign busy         = (state != IDLE) || start_stall;

  // A waitrequest-mode START is held from its first cycle until DONE;
  // in polling mode every write is held off until the controller is idle.
  always_comb begin
    mgmt_waitrequest = 1'b0;
    case (state)
      IDLE:    mgmt_waitrequest = start_stall;
      DONE:    mgmt_waitrequest = mgmt_write && !start_held;
      default: mgmt_waitrequest = mgmt_write;
    endcase
  end

  always_comb begin
    mgmt_readdata = 32'd0;
    if (mgmt_read && !mgmt_write) begin
      case (mgmt_address)
        ADDR_MODE:   mgmt_readdata = {31'd0, mode};
        ADDR_STATUS: mgmt_readdata = {29'd0, lock_s2, last_timeout, busy};
        ADDR_N:      mgmt_readdata = {16'd0, reg_n};
        ADDR_M:      mgmt_readdata = {16'd0, reg_m};
        ADDR_K:      mgmt_readdata = reg_k;
        default:     mgmt_readdata = 32'd0;
      endcase
    end
  end

  // Lock input is asynchronous to the management clock.
  always_ff @(posedge CLK_50M) begin
    lock_s1 <= pll_locked;
    lock_s2 <= lock_s1;
  end

  pll_cfg_shifter u_shifter (
    .clk   (CLK_50M),
    .rst   (RESET),
    .load  (start_go),
    .go    (state == SHIFT),
    .frame ({reg_k, reg_m, reg_n}),
    .sdata (cfg_sdata),
    .shift (cfg_shift),
    .last  (shift_last)
  );

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state        <= IDLE;
      mode         <= 1'b0;
      reg_n        <= 16'h0101;
      reg_m        <= 16'h0404;
      reg_k        <= 32'd0;
      last_timeout <= 1'b0;
      start_held   <= 1'b0;
      tmo_cnt      <= 16'd0;
      low_cnt      <= 8'd0;
      cfg_update   <= 1'b0;
    end else begin
      cfg_update <= (state == UPDATE);

      if (wr_accept) begin
        case (mgmt_address)
          ADDR_MODE: mode  <= mgmt_writedata[0];
          ADDR_N:    reg_n <= mgmt_writedata[15:0];
          ADDR_M:    reg_m <= mgmt_writedata[15:0];
          ADDR_K:    reg_k <= mgmt_writedata;
          default:   ;
        endcase
      end

      if (state == WAIT_UNLOCK || state == WAIT_LOCK) begin
        if (tmo_cnt != 16'hFFFF)
          tmo_cnt <= tmo_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (start_go) begin
            state        <= SHIFT;
            start_held   <= !mode;
            last_timeout <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_last)
            state <= UPDATE;
        end
        UPDATE: begin
          tmo_cnt <= 16'd0;
          low_cnt <= 8'd0;
          state   <= WAIT_UNLOCK;
        end
        WAIT_UNLOCK: begin
          if (tmo_cnt == LOCK_TIMEOUT) begin
            state        <= DONE;
            last_timeout <= 1'b1;
          end else if (!lock_s2) begin
            // The cycle where the count reads RELOCK_MIN-1 is the
            // RELOCK_MIN-th consecutive unlocked cycle.
            if (low_cnt == RELOCK_MIN - 8'd1)
              state <= WAIT_LOCK;
            low_cnt <= low_cnt + 8'd1;
          end else begin
            low_cnt <= 8'd0;
          end
        end
        WAIT_LOCK: begin
          if (tmo_cnt == LOCK_TIMEOUT) begin
            state        <= DONE;
            last_timeout <= 1'b1;
          end else if (lock_s2) begin
            state <= DONE;
          end
        end
        DONE: begin
          state      <= IDLE;
          start_held <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_cfg_responder.sv
// Directed bench for pll_cfg_responder: register vector table plus
// multi-cycle START sequences against a small PLL lock model.
module tb_pll_cfg_responder;

  localparam logic [15:0] T_OUT = 16'd400;
  localparam logic [31:0] OLD_K = 32'd3357876127;
  localparam logic [31:0] NEW_K = 32'd1503512573;

  logic        CLK_50M = 1'b0;
  logic        RESET = 1'b1;
  logic [5:0]  mgmt_address = 6'd0;
  logic        mgmt_write = 1'b0;
  logic        mgmt_read = 1'b0;
  logic [31:0] mgmt_writedata = 32'd0;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        cfg_sdata;
  logic        cfg_shift;
  logic        cfg_update;
  logic        pll_locked = 1'b1;
  logic        busy;

  always #10 CLK_50M = ~CLK_50M;

  pll_cfg_responder #(.LOCK_TIMEOUT(T_OUT), .RELOCK_MIN(8'd16)) dut (
    .CLK_50M          (CLK_50M),
    .RESET            (RESET),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .cfg_sdata        (cfg_sdata),
    .cfg_shift        (cfg_shift),
    .cfg_update       (cfg_update),
    .pll_locked       (pll_locked),
    .busy             (busy)
  );

  // PLL model: lock falls 20 cycles after the update strobe, returns 100 later.
  bit drop_en = 1'b0;
  int since_upd = -1;
  always @(negedge CLK_50M) begin
    if (cfg_update && drop_en)
      since_upd <= 0;
    else if (since_upd == 119)
      since_upd <= -1;
    else if (since_upd >= 0)
      since_upd <= since_upd + 1;
    if (since_upd == 19)
      pll_locked <= 1'b0;
    if (since_upd == 119)
      pll_locked <= 1'b1;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_wait;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    mgmt_write     = v.wr;
    mgmt_read      = v.rd;
    mgmt_address   = v.addr;
    mgmt_writedata = v.wdata;
    @(negedge CLK_50M);
    check({tag, "_wait"}, 64'(mgmt_waitrequest), 64'(v.exp_wait));
    check({tag, "_rdata"}, 64'(mgmt_readdata), 64'(v.exp_rdata));
    tick();
    mgmt_write = 1'b0;
    mgmt_read  = 1'b0;
  endtask

  task automatic start_polling(input string tag);
    mgmt_write   = 1'b1;
    mgmt_address = 6'd2;
    @(negedge CLK_50M);
    check({tag, "_start_nowait"}, 64'(mgmt_waitrequest), 64'd0);
    tick();
    mgmt_write = 1'b0;
  endtask

  initial begin
    logic [63:0] stream;
    logic [29:0] exp30;
    int bits, upd_cyc, upd_n, done_cyc, stalls;
    bit done;

    vecs.push_back('{1'b0, 1'b1, 6'd0, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd3, 32'd0,          32'h0000_0101,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd4, 32'd0,          32'h0000_0404,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd7, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd1, 32'd0,          32'h0000_0004,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd5, 32'hFFFF_FFFF,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd5, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd3, 32'hABCD_1234,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd3, 32'd0,          32'h0000_1234,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd3, 32'h0000_0101,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd3, 32'd0,          32'h0000_0101,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd4, 32'h0000_BEEF,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd4, 32'd0,          32'h0000_BEEF,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd4, 32'h0000_0404,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd4, 32'd0,          32'h0000_0404,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd0, 32'hFFFF_FFFE,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd0, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd0, 32'h0000_0001,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd0, 32'd0,          32'h0000_0001,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd0, 32'h0000_0000,  32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd0, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd7, OLD_K,          32'd0,          1'b0});
    vecs.push_back('{1'b0, 1'b1, 6'd7, 32'd0,          OLD_K,          1'b0});

    RESET = 1'b1;
    repeat (5) tick();
    RESET = 1'b0;
    @(negedge CLK_50M);
    check("rst_cfg_shift", 64'(cfg_shift), 64'd0);
    check("rst_cfg_update", 64'(cfg_update), 64'd0);
    check("rst_cfg_sdata", 64'(cfg_sdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wait", 64'(mgmt_waitrequest), 64'd0);
    check("rst_rdata", 64'(mgmt_readdata), 64'd0);
    tick();

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Waitrequest-mode START: stalled until DONE, full frame shifted out.
    drop_en = 1'b1;
    mgmt_write = 1'b1; mgmt_address = 6'd2; mgmt_writedata = 32'd0;
    stream = '0; bits = 0; upd_cyc = -1; upd_n = 0; done = 1'b0; done_cyc = -1;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge CLK_50M);
      if (c == 0) begin
        check("wr_busy_first", 64'(busy), 64'd1);
        check("wr_stall_first", 64'(mgmt_waitrequest), 64'd1);
      end
      if (cfg_shift) begin
        stream = {stream[62:0], cfg_sdata};
        bits++;
      end
      if (cfg_update) begin
        upd_n++;
        if (upd_cyc < 0) upd_cyc = c;
      end
      if (!mgmt_waitrequest) begin
        done = 1'b1;
        done_cyc = c;
        check("wr_busy_in_done", 64'(busy), 64'd1);
      end
      tick();
    end
    mgmt_write = 1'b0;
    check("wr_done_seen", 64'(done), 64'd1);
    check("wr_bits", 64'(bits), 64'd64);
    check("wr_stream", stream, {OLD_K, 16'h0404, 16'h0101});
    check("wr_update_cycle", 64'(upd_cyc), 64'd66);
    check("wr_update_pulses", 64'(upd_n), 64'd1);
    check("wr_min_latency", 64'(done_cyc >= 85 && done_cyc < 66 + int'(T_OUT)), 64'd1);
    apply_vec('{1'b0, 1'b1, 6'd1, 32'd0, 32'h0000_0004, 1'b0}, "wr_status_after");

    // Polling mode: START completes at once, STATUS busy until relock.
    apply_vec('{1'b1, 1'b0, 6'd0, 32'd1, 32'd0, 1'b0}, "poll_mode_wr");
    start_polling("poll");
    mgmt_read = 1'b1; mgmt_address = 6'd1;
    done = 1'b0; stalls = 0;
    for (int c = 1; c < 1000 && !done; c++) begin
      @(negedge CLK_50M);
      if (c == 1) check("poll_status_busy", 64'(mgmt_readdata[0]), 64'd1);
      if (mgmt_waitrequest) stalls++;
      if (!mgmt_readdata[0]) begin
        done = 1'b1;
        check("poll_status_final", 64'(mgmt_readdata), 64'h4);
      end
      tick();
    end
    mgmt_read = 1'b0;
    check("poll_done_seen", 64'(done), 64'd1);
    check("poll_read_stalls", 64'(stalls), 64'd0);

    // Timeout with a K write issued mid-shift; lock never drops.
    drop_en = 1'b0;
    start_polling("tmo");
    stream = '0; bits = 0; done = 1'b0; done_cyc = -1;
    for (int c = 1; c < 1000 && !done; c++) begin
      if (c == 10) begin
        mgmt_write = 1'b1; mgmt_address = 6'd7; mgmt_writedata = NEW_K;
      end
      @(negedge CLK_50M);
      if (c == 10) check("midshift_stall", 64'(mgmt_waitrequest), 64'd1);
      if (cfg_shift) begin
        stream = {stream[62:0], cfg_sdata};
        bits++;
      end
      if (mgmt_write && !mgmt_waitrequest) begin
        done = 1'b1;
        done_cyc = c;
      end
      tick();
    end
    mgmt_write = 1'b0;
    check("tmo_done_seen", 64'(done), 64'd1);
    check("tmo_old_frame", stream, {OLD_K, 16'h0404, 16'h0101});
    check("tmo_release_cycle", 64'(done_cyc), 64'(68 + int'(T_OUT)));
    apply_vec('{1'b0, 1'b1, 6'd1, 32'd0, 32'h0000_0006, 1'b0}, "tmo_status");
    apply_vec('{1'b0, 1'b1, 6'd7, 32'd0, NEW_K, 1'b0}, "tmo_new_k");

    // Next START clears last_timeout, shifts the new K; reset at bit 30.
    start_polling("rst");
    mgmt_read = 1'b1; mgmt_address = 6'd1;
    stream = '0; bits = 0;
    for (int c = 1; c < 200 && bits < 30; c++) begin
      @(negedge CLK_50M);
      if (c == 1) check("rst_status_cleared", 64'(mgmt_readdata), 64'h5);
      if (cfg_shift) begin
        stream = {stream[62:0], cfg_sdata};
        bits++;
      end
      if (bits == 30) RESET = 1'b1;
      else tick();
    end
    check("rst_reached_bit30", 64'(bits), 64'd30);
    exp30 = NEW_K[31:2];
    check("rst_new_k_bits", 64'(stream[29:0]), 64'(exp30));
    tick();
    @(negedge CLK_50M);
    check("rst_mid_shift", 64'(cfg_shift), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    tick();
    RESET = 1'b0;
    mgmt_read = 1'b0;
    apply_vec('{1'b0, 1'b1, 6'd7, 32'd0, 32'd0, 1'b0}, "rst_k_cleared");
    apply_vec('{1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 1'b0}, "rst_mode_cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
